// File: rtl/fifo_ser_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ser_pkg
// Shared types and default sizes for the FIFO word serializer slice.
//   ser_state_t : serializer FSM states (idle / sending a held word)
//   SER_WORD_W  : default FIFO word width
//   SER_BYTE_W  : default output byte width
//   SER_CNT_W   : default completed-word counter width
// -----------------------------------------------------------------------------
package fifo_ser_pkg;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    localparam int SER_WORD_W = 32;
    localparam int SER_BYTE_W = 8;
    localparam int SER_CNT_W  = 16;

endpackage : fifo_ser_pkg

// File: rtl/fifo_word_serializer_if.sv
// -----------------------------------------------------------------------------
// fifo_word_serializer_if
// Bundles the FIFO show-ahead read port and the byte-stream valid/ready port.
//   fifo_data  : FIFO head word (valid while fifo_empty = 0)
//   fifo_empty : FIFO empty flag
//   fifo_read  : pop strobe toward the FIFO
//   out_data   : current output byte
//   out_valid  : output byte valid
//   out_ready  : consumer accepts the byte
//   out_last   : byte is the final lane of its word
//   out_parity : even-parity bit of out_data (only with FIFO_SER_PARITY_EN)
// modport master : the serializer side
// modport slave  : the FIFO + consumer side
// Optional feature macro: FIFO_SER_PARITY_EN
// -----------------------------------------------------------------------------
interface fifo_word_serializer_if
    import fifo_ser_pkg::*;
#(
    parameter int WORD_W = SER_WORD_W,
    parameter int BYTE_W = SER_BYTE_W
);
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_read;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
`ifdef FIFO_SER_PARITY_EN
    logic              out_parity;
`endif

    modport master (
        input  fifo_data, fifo_empty, out_ready,
`ifdef FIFO_SER_PARITY_EN
        output out_parity,
`endif
        output fifo_read, out_data, out_valid, out_last
    );

    modport slave (
        output fifo_data, fifo_empty, out_ready,
`ifdef FIFO_SER_PARITY_EN
        input  out_parity,
`endif
        input  fifo_read, out_data, out_valid, out_last
    );

endinterface : fifo_word_serializer_if

// File: rtl/fifo_word_serializer.sv
// -----------------------------------------------------------------------------
// fifo_word_serializer
// Drains words from a show-ahead FIFO and emits them as a byte stream, least
// significant byte first, at up to one byte per cycle with no bubble between
// consecutive words.
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset
//   clear      : synchronous flush, same cycle as the FIFO clear
//   bus        : fifo_word_serializer_if.master (FIFO read port + byte stream)
//   busy       : a word is held (same as out_valid)
//   word_count : saturating count of fully transmitted words
// Optional feature macro: FIFO_SER_PARITY_EN adds bus.out_parity = ^out_data.
// -----------------------------------------------------------------------------
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int WORD_W = SER_WORD_W,
    parameter int BYTE_W = SER_BYTE_W,
    parameter int CNT_W  = SER_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    fifo_word_serializer_if.master bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      word_count
);

    localparam int LANES = WORD_W / BYTE_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    ser_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] hold_q;
    logic              sending;
    logic              last_lane;
    logic              load;

    assign sending   = (state_q == SER_SEND);
    // Gated by state so out_last reads 0 while idle even though idx is stale.
    assign last_lane = sending && (idx_q == IDX_W'(LANES - 1));

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (!reset && !clear && !bus.fifo_empty) begin
                    load    = 1'b1;
                    state_d = SER_SEND;
                end
            end
            SER_SEND: begin
                // Final-lane handshake: chain straight into the next word if
                // one is waiting, which is what keeps the stream bubble-free.
                if (bus.out_ready && last_lane) begin
                    if (!reset && !clear && !bus.fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q    <= SER_IDLE;
            idx_q      <= '0;
            // NOTE: the word register is cleared so a flushed word can never
            // reappear on out_data; it is a single register, not a memory.
            hold_q     <= '0;
            word_count <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                hold_q <= bus.fifo_data;
                idx_q  <= '0;
            end else if (sending && bus.out_ready && !last_lane) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (sending && bus.out_ready && last_lane && (word_count != '1)) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

    assign bus.fifo_read = load;
    assign bus.out_valid = sending;
    assign bus.out_last  = last_lane;
    assign bus.out_data  = sending ? hold_q[idx_q*BYTE_W +: BYTE_W] : '0;
    assign busy          = sending;

`ifdef FIFO_SER_PARITY_EN
    // Set when out_data has an odd number of ones, making the 9-bit group even.
    assign bus.out_parity = ^bus.out_data;
`endif

endmodule : fifo_word_serializer
